// File: rtl/motor_timer_unit.sv
// -----------------------------------------------------------------------------
// motor_timer_unit
//
// Clocked replacement for the behavioural delay timers used by the motor and
// LED sequencing FSMs. There are two identical channels. Each one answers a
// level request with a level "done" exactly N clock cycles after the request
// is first sampled, where N = ticks * PRESCALE.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   req1   in   channel 1 request (EN1 | Timer1), level, long interval
//   req2   in   channel 2 request (EN2 | Timer2), level, short interval
//   stop   in   synchronous abort of both channels, level
//   done1  out  channel 1 interval elapsed, level
//   done2  out  channel 2 interval elapsed, level
//   busy1  out  channel 1 counting
//   busy2  out  channel 2 counting
//   exp1   out  one-cycle pulse on the cycle done1 rises
//   exp2   out  one-cycle pulse on the cycle done2 rises
// -----------------------------------------------------------------------------
module motor_timer_unit #(
    parameter int PRESCALE = 4,
    parameter int T1_TICKS = 10,
    parameter int T2_TICKS = 5,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req1,
    input  logic req2,
    input  logic stop,
    output logic done1,
    output logic done2,
    output logic busy1,
    output logic busy2,
    output logic exp1,
    output logic exp2
);

    localparam int N1 = T1_TICKS * PRESCALE;
    localparam int N2 = T2_TICKS * PRESCALE;

    // Refuse to build a timer whose counter cannot hold the interval.
    generate
        if (PRESCALE < 1 || T1_TICKS < 1 || T2_TICKS < 1 ||
            (2 ** CNT_W) <= N1 || (2 ** CNT_W) <= N2) begin : g_bad_params
            $error("motor_timer_unit: illegal PRESCALE/T*_TICKS/CNT_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [1:0] req_vec;
    logic [1:0] done_vec;
    logic [1:0] busy_vec;
    logic [1:0] exp_vec;

    assign req_vec = {req2, req1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            localparam int N = (gi == 0) ? N1 : N2;
            // The prescaler and tick count are folded into one down-counter
            // that is loaded at RUN entry, so the interval always starts from
            // the sampling edge rather than from some shared tick phase.
            localparam logic [CNT_W-1:0] LOAD = CNT_W'(N - 1);

            state_t           state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             exp_reg, exp_next;
            logic             done_c, busy_c, exp_c;

            // State register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    exp_reg   <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    exp_reg   <= exp_next;
                end
            end

            // Next-state logic. stop wins over both request and expiry.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                exp_next   = 1'b0;
                if (stop) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    unique case (state_reg)
                        ST_IDLE: begin
                            if (req_vec[gi]) begin
                                state_next = ST_RUN;
                                cnt_next   = LOAD;
                            end
                        end
                        ST_RUN: begin
                            if (!req_vec[gi]) begin
                                state_next = ST_IDLE;
                                cnt_next   = '0;
                            end else if (cnt_reg == '0) begin
                                state_next = ST_DONE;
                                exp_next   = 1'b1;
                            end else begin
                                cnt_next = cnt_reg - CNT_W'(1);
                            end
                        end
                        ST_DONE: begin
                            if (!req_vec[gi]) begin
                                state_next = ST_IDLE;
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            // Outputs decode registered state only.
            always_comb begin
                done_c = (state_reg == ST_DONE);
                busy_c = (state_reg == ST_RUN);
                exp_c  = exp_reg;
            end

            assign done_vec[gi] = done_c;
            assign busy_vec[gi] = busy_c;
            assign exp_vec[gi]  = exp_c;
        end
    endgenerate

    assign done1 = done_vec[0];
    assign done2 = done_vec[1];
    assign busy1 = busy_vec[0];
    assign busy2 = busy_vec[1];
    assign exp1  = exp_vec[0];
    assign exp2  = exp_vec[1];

endmodule

// File: doc/motor_timer_unit.md
Name: motor_timer_unit

Overview:
- Synthesizable, clocked responder for the timer-request handshake of the motor and LED sequencing FSMs.
- Two independent channels:
  - Channel 1: long interval, driven by the motor-enable OR LED-timer-1 request.
  - Channel 2: short interval, driven by the motor-enable-2 OR LED-timer-2 request.
- Replaces the behavioural delay timers. Each channel returns a level "done" after a fixed number of prescaled ticks.
- The global stop input aborts both channels.

Parameters:
- PRESCALE, 4, clock cycles per timer tick (must be >= 1).
- T1_TICKS, 10, channel 1 interval in ticks (must be >= 1).
- T2_TICKS, 5, channel 2 interval in ticks (must be >= 1).
- CNT_W, 8, counter width. Must satisfy 2^CNT_W > T1_TICKS*PRESCALE and 2^CNT_W > T2_TICKS*PRESCALE; otherwise elaboration fails.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req1  input  1  channel 1 request, level (EN1 OR Timer1).
- req2  input  1  channel 2 request, level (EN2 OR Timer2).
- stop  input  1  synchronous abort, level (S).
- done1  output  1  channel 1 interval elapsed, level.
- done2  output  1  channel 2 interval elapsed, level.
- busy1  output  1  channel 1 counting.
- busy2  output  1  channel 2 counting.
- exp1  output  1  one-cycle pulse on the cycle done1 rises.
- exp2  output  1  one-cycle pulse on the cycle done2 rises.

Behaviour:
- Reset (reset=0, asynchronous): both channels go to IDLE. All counters are 0. done*, busy*, exp* are 0. Outputs stay 0 until the first rising clk edge after reset=1.
- All outputs are registered; none is a combinational function of the inputs.
- Channels are identical except for N = T1_TICKS*PRESCALE (channel 1) or T2_TICKS*PRESCALE (channel 2). Defaults: N1=40, N2=20.
- Per-channel FSM, with states IDLE, RUN, DONE. Each channel keeps a counter cnt[CNT_W-1:0].
- IDLE (done=0, busy=0):
  - On an edge with req=1 and stop=0: go to RUN, load cnt=N-1, busy=1.
  - Otherwise stay in IDLE.
- RUN (busy=1, done=0):
  - Each edge with req=1, stop=0, cnt!=0: decrement cnt.
  - Edge with req=1, stop=0, cnt==0: go to DONE, done=1, exp=1 for that cycle, busy=0.
  - Edge with req=0: cancel. Go to IDLE with no done and no exp.
- DONE (done=1, busy=0):
  - Hold while req=1 and stop=0. exp is 0 after the first cycle.
  - Edge with req=0: go to IDLE, done=0.
- Latency: req first sampled 1 at edge k means done=1 and exp=1 are visible after edge k+N, i.e. exactly N cycles later.
- Re-trigger: a req 1->0->1 sequence restarts the full interval from the new sampling edge. No residual count is carried over.
- stop=1 on any edge forces both channels to IDLE. done, busy and exp clear on that edge, and no request is accepted while stop=1. stop has priority over req and over expiry on the same edge.
- Simultaneous expiry on both channels is allowed. exp1 and exp2 pulse in the same cycle.
- Reset asserted mid-RUN or in DONE clears immediately and asynchronously. No pending pulse survives.
- The counter never wraps. Decrement only occurs when cnt!=0.
- The tick count is realised with a per-channel prescaler started at RUN entry. No free-running shared prescaler is used, which keeps latency deterministic.

Test Plan:
- Reset, then idle: hold reset=0 for 3 cycles with req1=req2=1 → all outputs 0. Release reset → busy1=busy2=1 after the first edge; done2 and exp2 high 20 cycles later; done1 and exp1 high 40 cycles later; each exp high for exactly 1 cycle.
- Hold and release: req2=1 for 30 cycles, then 0 → done2 high from cycle 20 to cycle 30 inclusive of hold, low on the edge after req2 falls, busy2 back to 0.
- Cancel: req1=1 for 25 cycles, then 0 for 1 cycle, then 1 → no done1 or exp1 during the first burst; done1 rises 40 cycles after the second rising sample.
- Stop abort: req1=req2=1, stop=1 at cycle 15 for 2 cycles → busy/done all 0 from the stop edge. After stop=0 with req still 1, intervals restart: done2 at +20, done1 at +40. Separately, stop coinciding with the expiry edge → no exp pulse.
- Simultaneous expiry: PRESCALE=4, T1_TICKS=T2_TICKS=5, both reqs rise on the same edge → exp1=exp2=1 in the same cycle, 20 cycles later.
- Async reset mid-count: reset=0 asserted between edges at cycle 10 of channel 1 → busy1 drops without waiting for clk. After release with req1=1, the full 40-cycle interval elapses again.
